// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the VGA timing block.
// Defaults describe 640x480@60 with a 4:1 system-to-pixel clock ratio.
package vga_timing_pkg;

  // Counter width used for both the pixel and line counters.
  localparam int unsigned CNT_W         = 10;
  localparam int unsigned CNT_MAX_TOTAL = 1 << CNT_W;

  // Default 640x480@60 timing.
  localparam int unsigned DEF_CLK_DIV  = 4;
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam logic        DEF_SYNC_POL = 1'b0;

  typedef logic [CNT_W-1:0] cnt_t;

  // Pattern codes understood by the colour stage.
  typedef enum logic [1:0] {
    PAT_BLACK  = 2'd0,
    PAT_ORANGE = 2'd1,
    PAT_BARS   = 2'd2,
    PAT_GRID   = 2'd3
  } pattern_e;

  // Total period of one axis (line or frame) from its four segments.
  function automatic int unsigned timing_total(input int unsigned active,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_pix_div.sv
// Pixel-enable divider: a free-running 0..CLK_DIV-1 counter whose last
// count is presented as a registered one-clock strobe. Falling-edge design.
module vga_pix_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clock,
  input  logic res,
  output logic pix_en
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  if (CLK_DIV < 2) begin : g_bad_div
    $error("vga_pix_div: CLK_DIV must be at least 2");
  end

  logic [DW-1:0] div_q, div_d;
  logic          pix_en_q;

  // Next divider value: wrap after the last count.
  always_comb begin
    div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
  end

  // Divider state; the strobe is registered from the next divider value so it
  // is high exactly while the divider holds its last count.
  always_ff @(negedge clock or negedge res) begin
    if (!res) begin
      div_q    <= '0;
      pix_en_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples pre-edge values.
      div_q    <= div_d;
      pix_en_q <= (div_d == DIV_LAST);
    end
  end

  assign pix_en = pix_en_q;

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA timing controller: pixel/line counters, sync and display-enable decode,
// line/frame strobes and a frame-synchronous pattern-select shadow register.
// All state changes on the falling edge of clock.
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter logic        SYNC_POL = DEF_SYNC_POL
) (
  input  logic       clock,
  input  logic       res,
  input  logic       cfg_valid,
  input  logic [1:0] cfg_pattern,
  output logic       cfg_ready,
  output logic       pix_en,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       de,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start,
  output logic [1:0] pattern
);

  localparam int unsigned H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_TOTAL > CNT_MAX_TOTAL || V_TOTAL > CNT_MAX_TOTAL) begin : g_bad_total
    $error("vga_timing_ctrl: H_TOTAL/V_TOTAL exceed the 10-bit counter range");
  end

  localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_ACT    = cnt_t'(H_ACTIVE);
  localparam cnt_t V_ACT    = cnt_t'(V_ACTIVE);
  localparam cnt_t HS_FIRST = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t HS_LAST  = cnt_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam cnt_t VS_FIRST = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t VS_LAST  = cnt_t'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic SYNC_IDLE = ~SYNC_POL;

  // Counter and decoded timing state.
  cnt_t h_q, h_d;
  cnt_t v_q, v_d;
  logic de_q, de_d;
  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;

  // Pattern shadow: a captured request waits in shadow_q until a frame
  // boundary; apply_q marks the boundary clock so pending clears one clock
  // after the pattern switches.
  pattern_e pattern_q, pattern_d;
  pattern_e shadow_q, shadow_d;
  logic     pending_q, pending_d;
  logic     apply_q, apply_d;
  logic     xfer;

  vga_pix_div #(
    .CLK_DIV(CLK_DIV)
  ) u_pix_div (
    .clock (clock),
    .res   (res),
    .pix_en(pix_en)
  );

  // Next counter values and the outputs decoded from them, so the registered
  // outputs line up exactly with the registered counters.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    h_d = h_q;
    v_d = v_q;
    if (pix_en) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + cnt_t'(1);
      end else begin
        h_d = h_q + cnt_t'(1);
      end
    end
    de_d          = (h_d < H_ACT) && (v_d < V_ACT);
    hsync_d       = (h_d >= HS_FIRST && h_d <= HS_LAST) ? SYNC_POL : SYNC_IDLE;
    vsync_d       = (v_d >= VS_FIRST && v_d <= VS_LAST) ? SYNC_POL : SYNC_IDLE;
    line_start_d  = pix_en && (h_d == '0);
    frame_start_d = line_start_d && (v_d == '0);
  end

  // Config handshake and frame-synchronous pattern update.
  always_comb begin
    xfer      = cfg_valid && !pending_q;
    apply_d   = frame_start_d && pending_q;
    pattern_d = apply_d ? shadow_q : pattern_q;
    shadow_d  = xfer ? pattern_e'(cfg_pattern) : shadow_q;
    pending_d = pending_q;
    if (xfer) begin
      pending_d = 1'b1;
    end else if (apply_q) begin
      pending_d = 1'b0;
    end
  end

  // Timing registers.
  always_ff @(negedge clock or negedge res) begin
    if (!res) begin
      h_q           <= H_LAST;
      v_q           <= V_LAST;
      de_q          <= 1'b0;
      hsync_q       <= SYNC_IDLE;
      vsync_q       <= SYNC_IDLE;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      de_q          <= de_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Pattern shadow registers; reset discards any pending request.
  always_ff @(negedge clock or negedge res) begin
    if (!res) begin
      pattern_q <= PAT_BLACK;
      shadow_q  <= PAT_BLACK;
      pending_q <= 1'b0;
      apply_q   <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      apply_q   <= apply_d;
    end
  end

  assign cfg_ready   = ~pending_q;
  assign hcount      = h_q;
  assign vcount      = v_q;
  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign pattern     = pattern_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Testbench for vga_timing_ctrl. A reduced-timing instance is compared every
// clock against a closed-form timing model plus a pattern-handshake model via
// a scoreboard queue; a default-timing instance is measured over one line.
module tb_vga_timing_ctrl;
  import vga_timing_pkg::*;

  localparam int CD  = 4;
  localparam int HA  = 8;
  localparam int HFP = 2;
  localparam int HS  = 3;
  localparam int HBP = 3;
  localparam int VA  = 6;
  localparam int VFP = 1;
  localparam int VS  = 2;
  localparam int VBP = 2;
  localparam int HT  = HA + HFP + HS + HBP;  // 16
  localparam int VT  = VA + VFP + VS + VBP;  // 11
  localparam int FRAME = CD * HT * VT;       // 704 clocks

  logic       clock;
  logic       res;
  logic       cfg_valid;
  logic [1:0] cfg_pattern;
  logic       cfg_ready, pix_en, de, hsync, vsync, line_start, frame_start;
  logic [9:0] hcount, vcount;
  logic [1:0] pattern;

  logic       d_cfg_valid;
  logic [1:0] d_cfg_pattern;
  logic       d_cfg_ready, d_pix_en, d_de, d_hs, d_vs, d_ls, d_fs;
  logic [9:0] d_hcount, d_vcount;
  logic [1:0] d_pattern;

  vga_timing_ctrl #(
    .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(1'b0)
  ) u_dut (
    .clock(clock), .res(res), .cfg_valid(cfg_valid), .cfg_pattern(cfg_pattern),
    .cfg_ready(cfg_ready), .pix_en(pix_en), .hcount(hcount), .vcount(vcount),
    .de(de), .hsync(hsync), .vsync(vsync), .line_start(line_start),
    .frame_start(frame_start), .pattern(pattern)
  );

  vga_timing_ctrl u_dut_def (
    .clock(clock), .res(res), .cfg_valid(d_cfg_valid), .cfg_pattern(d_cfg_pattern),
    .cfg_ready(d_cfg_ready), .pix_en(d_pix_en), .hcount(d_hcount), .vcount(d_vcount),
    .de(d_de), .hsync(d_hs), .vsync(d_vs), .line_start(d_ls),
    .frame_start(d_fs), .pattern(d_pattern)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       pix_en;
    logic [9:0] h;
    logic [9:0] v;
    logic       de;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
    logic [1:0] pat;
    logic       rdy;
  } obs_t;

  typedef struct {
    int   h;
    int   v;
    logic de;
    logic hs;
    logic vs;
    logic ls;
    logic fs;
  } vec_t;

  vec_t vecs[13];

  // Model state: edges since reset release plus the pattern handshake.
  int       m_t;
  logic     m_pending, m_apply;
  logic [1:0] m_shadow, m_pattern;
  obs_t     sb_q[$];
  int       de_pix = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic obs_t sample_dut();
    return {pix_en, hcount, vcount, de, hsync, vsync, line_start, frame_start,
            pattern, cfg_ready};
  endfunction

  // Expected timing outputs t falling edges after reset release.
  function automatic obs_t timing_at(input int t);
    obs_t e;
    int p, ph, idx, h, v;
    e  = '0;
    p  = t / CD;
    ph = t % CD;
    if (p == 0) begin
      h = HT - 1;
      v = VT - 1;
    end else begin
      idx = (p - 1) % (HT * VT);
      h   = idx % HT;
      v   = idx / HT;
    end
    e.pix_en = (ph == CD - 1);
    e.h  = 10'(h);
    e.v  = 10'(v);
    e.de = (h < HA) && (v < VA);
    e.hs = !(h >= HA + HFP && h < HA + HFP + HS);
    e.vs = !(v >= VA + VFP && v < VA + VFP + VS);
    e.ls = (ph == 0) && (p > 0) && (h == 0);
    e.fs = e.ls && (v == 0);
    return e;
  endfunction

  task automatic model_reset();
    m_t = 0;
    m_pending = 1'b0;
    m_apply = 1'b0;
    m_shadow = 2'd0;
    m_pattern = 2'd0;
    sb_q.delete();
  endtask

  // Drive inputs for one clock, push the expected post-edge state, then
  // compare it with the DUT on the following rising edge.
  task automatic step(input logic v, input logic [1:0] p);
    obs_t e, got;
    logic xfer, apply_n;
    cfg_valid = v;
    cfg_pattern = p;
    xfer = v && !m_pending;
    m_t++;
    e = timing_at(m_t);
    apply_n = e.fs && m_pending;
    if (apply_n) m_pattern = m_shadow;
    if (xfer) begin
      m_pending = 1'b1;
      m_shadow = p;
    end else if (m_apply) begin
      m_pending = 1'b0;
    end
    m_apply = apply_n;
    e.pat = m_pattern;
    e.rdy = !m_pending;
    sb_q.push_back(e);
    @(posedge clock);
    got = sample_dut();
    e = sb_q.pop_front();
    check($sformatf("cycle t=%0d", m_t), got, e);
    if (m_t >= CD && m_t < CD + FRAME && got.de && got.pix_en) de_pix++;
  endtask

  task automatic run_to(input int h, input int v);
    obs_t e;
    int n = 0;
    e = timing_at(m_t);
    while (!((m_t % CD) == 0 && m_t > 0 && e.h == 10'(h) && e.v == 10'(v))
           && n < 2 * FRAME + CD) begin
      step(1'b0, 2'd0);
      n++;
      e = timing_at(m_t);
    end
    if (n >= 2 * FRAME + CD) begin
      checks++;
      errors++;
      $display("FAIL run_to(%0d,%0d): position not reached in %0d clocks", h, v, n);
    end
  endtask

  task automatic run_to_fs();
    obs_t e;
    int n = 0;
    do begin
      step(1'b0, 2'd0);
      n++;
      e = timing_at(m_t);
    end while (!e.fs && n < 2 * FRAME);
    if (!e.fs) begin
      checks++;
      errors++;
      $display("FAIL run_to_fs: no frame start in %0d clocks", n);
    end
  endtask

  // Default-timing instance: measure the first full line after reset release.
  int cyc = 0, ls_n = 0, ls_t0 = 0, ls_t1 = 0, hs_cnt = 0, def_de_cnt = 0;
  logic [9:0] hs_h0 = '0;
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (res) begin
      if (d_ls) begin
        ls_n <= ls_n + 1;
        if (ls_n == 0) ls_t0 <= cyc;
        if (ls_n == 1) ls_t1 <= cyc;
      end
      if ((ls_n == 0 && d_ls) || (ls_n == 1 && !d_ls)) begin
        if (!d_hs) begin
          hs_cnt <= hs_cnt + 1;
          if (hs_cnt == 0) hs_h0 <= d_hcount;
        end
        if (d_de) def_de_cnt <= def_de_cnt + 1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{0,  0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[1]  = '{7,  0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{8,  0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{10, 0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{12, 0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{13, 0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{7,  5,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{15, 5,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{0,  6,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{0,  7,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{12, 8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{0,  9,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{15, 10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    res = 1'b0;
    cfg_valid = 1'b0;
    cfg_pattern = 2'd0;
    d_cfg_valid = 1'b0;
    d_cfg_pattern = 2'd0;
    model_reset();

    // Reset state, held for 10 clocks.
    repeat (10) @(posedge clock);
    check("rst_hcount", hcount, HT - 1);
    check("rst_vcount", vcount, VT - 1);
    check("rst_de", de, 1'b0);
    check("rst_hsync", hsync, 1'b1);
    check("rst_vsync", vsync, 1'b1);
    check("rst_pix_en", pix_en, 1'b0);
    check("rst_strobes", {line_start, frame_start}, 2'b00);
    check("rst_pattern", pattern, PAT_BLACK);
    check("rst_cfg_ready", cfg_ready, 1'b1);
    check("def_rst_hcount", d_hcount, 799);
    check("def_rst_vcount", d_vcount, 524);
    check("def_rst_syncs", {d_hs, d_vs, d_de}, 3'b110);
    res = 1'b1;

    // Decode boundaries across the first frame.
    for (int i = 0; i < 13; i++) begin
      while (m_t < CD * (1 + vecs[i].v * HT + vecs[i].h)) step(1'b0, 2'd0);
      check($sformatf("vec%0d_hcount", i), hcount, vecs[i].h);
      check($sformatf("vec%0d_vcount", i), vcount, vecs[i].v);
      check($sformatf("vec%0d_de", i), de, vecs[i].de);
      check($sformatf("vec%0d_hsync", i), hsync, vecs[i].hs);
      check($sformatf("vec%0d_vsync", i), vsync, vecs[i].vs);
      check($sformatf("vec%0d_line_start", i), line_start, vecs[i].ls);
      check($sformatf("vec%0d_frame_start", i), frame_start, vecs[i].fs);
    end
    while (m_t < 3300) step(1'b0, 2'd0);
    check("frame_de_pixels", de_pix, HA * VA);
    check("def_line_period", ls_t1 - ls_t0, 3200);
    check("def_hsync_clocks", hs_cnt, 384);
    check("def_hsync_first_h", hs_h0, 656);
    check("def_de_clocks", def_de_cnt, 2560);

    // Mid-frame request: held until the next frame start; extra request ignored.
    run_to(5, 3);
    step(1'b1, PAT_ORANGE);
    check("cfg_ready_low", cfg_ready, 1'b0);
    check("pattern_hold", pattern, PAT_BLACK);
    repeat (3) step(1'b1, PAT_GRID);
    run_to_fs();
    check("pattern_at_fs", pattern, PAT_ORANGE);
    check("ready_at_fs", cfg_ready, 1'b0);
    step(1'b0, 2'd0);
    check("ready_after_fs", cfg_ready, 1'b1);

    // Transfer during the frame-start clock waits one more frame.
    run_to_fs();
    step(1'b1, PAT_BARS);
    check("sim_ready_low", cfg_ready, 1'b0);
    check("sim_pattern_kept", pattern, PAT_ORANGE);
    run_to(15, 10);
    check("sim_pattern_end", pattern, PAT_ORANGE);
    run_to_fs();
    check("sim_pattern_next", pattern, PAT_BARS);
    step(1'b0, 2'd0);
    check("sim_ready_back", cfg_ready, 1'b1);

    // Asynchronous reset mid-frame with a pending request.
    run_to(5, 4);
    step(1'b1, PAT_GRID);
    step(1'b0, 2'd0);
    #2 res = 1'b0;
    #1;
    check("arst_hcount", hcount, HT - 1);
    check("arst_vcount", vcount, VT - 1);
    check("arst_de_syncs", {de, hsync, vsync}, 3'b011);
    check("arst_strobes", {pix_en, line_start, frame_start}, 3'b000);
    check("arst_pattern", pattern, PAT_BLACK);
    check("arst_cfg_ready", cfg_ready, 1'b1);
    model_reset();
    repeat (3) @(posedge clock);
    res = 1'b1;
    repeat (3) step(1'b0, 2'd0);
    check("restart_pix_en", pix_en, 1'b1);
    step(1'b0, 2'd0);
    check("restart_fs", {frame_start, line_start}, 2'b11);
    check("restart_pos", {hcount, vcount}, 20'd0);
    run_to_fs();
    step(1'b0, 2'd0);
    check("restart_pattern", pattern, PAT_BLACK);
    check("restart_ready", cfg_ready, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
